// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: small in-order buffer with valid/ready on both
// sides, synchronous squash, and a saturating back-pressure counter.
module pipe_stage_buf #(
  parameter int DATA_W = 104,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16,
  parameter int OCC_W  = $clog2(DEPTH+1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH-1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              push, pop;

  assign in_ready  = reset & (occ_q < FULL_OCC);
  assign out_valid = (occ_q != '0);
  // Storage is never cleared, so the bubble must be masked to zero here.
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign occupancy = occ_q;
  assign stall_cnt = stall_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    stall_d  = stall_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    if (out_valid && !out_ready && stall_q != '1) stall_d = stall_q + 1'b1;
    // Squash drops everything, including a same-cycle push; the stall count survives.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      stall_q  <= stall_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) mem_q[wr_ptr_q] <= in_data;
  end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed + randomized bench for pipe_stage_buf against a queue-based reference model.
module tb_pipe_stage_buf;
  localparam int DATA_W = 104;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 4;
  localparam int OCC_W  = $clog2(DEPTH+1);
  localparam int SAT    = (1 << CNT_W) - 1;

  logic              clock = 1'b0;
  logic              reset, in_valid, in_ready, out_valid, out_ready, flush;
  logic [DATA_W-1:0] in_data, out_data;
  logic [OCC_W-1:0]  occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  always #5 clock = ~clock;

  pipe_stage_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] mq[$];
  int m_stall = 0;
  bit known = 0;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks outputs against the model, then advances model and DUT by one edge.
  task automatic cycle();
    logic [DATA_W-1:0] exp_d;
    bit push, pop;
    int sz;
    #1;
    sz = mq.size();
    if (known) begin
      exp_d = (sz != 0) ? mq[0] : '0;
      chk("in_ready",  in_ready,  reset && sz < DEPTH);
      chk("out_valid", out_valid, sz != 0);
      chk("out_data",  out_data,  exp_d);
      chk("occupancy", occupancy, sz);
      chk("stall_cnt", stall_cnt, m_stall);
    end
    push = reset && in_valid && sz < DEPTH;
    pop  = reset && sz != 0 && out_ready;
    @(posedge clock);
    if (!reset) begin
      mq.delete();
      m_stall = 0;
      known = 1;
    end else begin
      if (sz != 0 && !out_ready && m_stall < SAT) m_stall++;
      if (pop) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (push) mq.push_back(in_data);
    end
    @(negedge clock);
  endtask

  task automatic drv(bit r, bit iv, logic [DATA_W-1:0] d, bit ordy, bit fl);
    reset = r; in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    cycle();
  endtask

  initial begin
    int got;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    @(negedge clock);

    // reset held with a pending upstream bundle
    drv(0, 1, 'hABCD, 0, 0);
    drv(0, 1, 'hABCD, 0, 0);
    drv(1, 0, '0, 0, 0);

    // one-cycle latency, in order
    drv(1, 1, 'h00400000, 1, 0);
    chk("lat0_data", out_data, 'h00400000);
    drv(1, 1, 'h00400004, 1, 0);
    chk("lat1_data", out_data, 'h00400004);
    drv(1, 0, '0, 1, 0);
    drv(1, 0, '0, 1, 0);

    // back-pressure: C held upstream while full
    drv(1, 1, 'hA, 0, 0);
    drv(1, 1, 'hB, 0, 0);
    repeat (3) drv(1, 1, 'hC, 0, 0);
    chk("bp_full", in_ready, 1'b0);
    drv(1, 1, 'hC, 1, 0);
    drv(1, 1, 'hC, 1, 0);
    drv(1, 0, '0, 1, 0);
    drv(1, 0, '0, 1, 0);

    // full throughput: 100 beats, 101 cycles
    got = 0;
    for (int i = 0; i <= 100; i++) begin
      drv(1, i < 100, DATA_W'(i), 1, 0);
      if (out_valid) begin
        chk("thru_data", out_data, got);
        got++;
      end
    end
    chk("thru_count", got, 100);

    // flush with simultaneous push and pop
    drv(1, 1, 'hA5, 0, 0);
    drv(1, 1, 'hB6, 0, 0);
    drv(1, 1, 'hDD, 1, 1);
    chk("flush_occ", occupancy, 0);
    chk("flush_data", out_data, 0);
    repeat (3) drv(1, 0, '0, 1, 0);

    // saturation, then mid-operation reset
    drv(1, 1, 'h11, 0, 0);
    drv(1, 1, 'h12, 0, 0);
    repeat (20) drv(1, 0, '0, 0, 0);
    chk("stall_sat", stall_cnt, SAT);
    drv(0, 1, 'h99, 0, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_stall", stall_cnt, 0);
    drv(1, 1, 'h21, 1, 0);
    drv(1, 1, 'h22, 1, 0);
    drv(1, 0, '0, 1, 0);

    // random traffic with occasional flush and reset
    repeat (400) begin
      drv($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
          DATA_W'({$urandom, $urandom, $urandom, $urandom}),
          $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end
    drv(1, 0, '0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised, elastic pipeline-stage register. It is the successor to the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) in the 5-stage CPU. It carries one stage bundle through a small in-order buffer with valid/ready handshaking on both sides, a synchronous flush for branch/exception squash, and a saturating back-pressure counter for performance analysis. One instance sits between each pair of pipeline stages.

Parameters:
DATA_W, 104, width of the stage bundle (default = c 32 + data_read 32 + pc 32 + data_write sel 2 + num_write 5 + reg_write 1)
DEPTH, 2, number of buffer entries; legal range 2..8, need not be a power of two
CNT_W, 16, width of the stall counter
OCC_W, $clog2(DEPTH+1), derived; width of the occupancy output

Ports:
clock  in  1  single clock; all state updates on posedge
reset  in  1  synchronous, active-low reset
in_valid  in  1  upstream stage presents a bundle
in_ready  out  1  buffer can accept a bundle this cycle
in_data  in  DATA_W  upstream bundle
out_valid  out  1  head entry is valid
out_ready  in  1  downstream stage consumes the head this cycle
out_data  out  DATA_W  head bundle
flush  in  1  squash all buffered bundles
occupancy  out  OCC_W  number of valid entries
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset: if reset=0 at posedge, all entries become invalid. After that edge: occupancy=0, out_valid=0, out_data=0, stall_cnt=0, read and write pointers=0. While reset=0, in_ready=0 combinationally. Reset dominates flush and all handshakes.
- Push: occurs when in_valid & in_ready at posedge. in_data is written at the write pointer, and the write pointer advances modulo DEPTH.
- Pop: occurs when out_valid & out_ready at posedge. The read pointer advances modulo DEPTH.
- Ordering: strict FIFO; no reordering and no duplication.
- in_ready = reset & (occupancy < DEPTH). It is a function of registered state only; there is no combinational path from out_ready or in_valid to in_ready.
- out_valid = (occupancy != 0). out_data = entry at read pointer when out_valid=1, and all zeros when out_valid=0 (bubble = zero bundle). There is no combinational path from in_* to out_*.
- Latency: a bundle pushed at edge N into an empty buffer is visible on out_* after edge N, i.e. one cycle. There is no pass-through.
- Throughput: with out_ready held at 1 and in_valid held at 1, the buffer sustains one bundle per cycle at DEPTH >= 2.
- Occupancy update per edge: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full: in_ready=0, and in_valid is ignored. A pop in the same cycle frees a slot for the next cycle only.
- Empty: out_valid=0 and out_ready is ignored. A push in the same cycle appears next cycle.
- Hold: while out_valid=1 and out_ready=0, out_valid and out_data remain stable.
- Flush: flush=1 at posedge (with reset=1) invalidates all entries.
  - occupancy becomes 0 and both pointers return to 0.
  - A push in the same cycle is discarded.
  - A pop in the same cycle counts as delivered.
  - stall_cnt is not cleared by flush.
- stall_cnt increments at each posedge where out_valid=1 and out_ready=0. It saturates at 2^CNT_W-1 and never wraps. It is cleared only by reset.
- Pointer wrap: pointers count 0..DEPTH-1 and return to 0, so non-power-of-two DEPTH is correct.
- Storage is not cleared on pop or flush; only the valid accounting changes. out_data masking guarantees the zero bubble.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with in_valid=1, in_data=0xABCD -> in_ready=0, out_valid=0, out_data=0, occupancy=0, stall_cnt=0. Release reset -> in_ready=1 next cycle.
2. Latency and order: with out_ready=1, push pc=0x00400000 then 0x00400004 on consecutive cycles -> each appears on out_data exactly one cycle after its push, in order, with occupancy never exceeding 1.
3. Back-pressure with DEPTH=2 and out_ready=0: push A, B, C -> A and B accepted, in_ready=0 from occupancy 2, and C is held upstream. stall_cnt increments each stalled cycle. Assert out_ready -> A, B, C are delivered in order.
4. Full throughput: 100 beats with in_valid=1 and out_ready=1 -> 100 outputs in 101 cycles, no gaps, and data matches input sequence 0..99.
5. Flush: occupancy=2, then flush=1 with a simultaneous push of D and pop of the head -> next cycle occupancy=0, out_valid=0, out_data=0, and D never appears. stall_cnt is unchanged except for the normal rule.
6. Saturation and mid-operation reset with CNT_W=4: stall for 20 cycles -> stall_cnt=15 and holds. Then reset=0 for one cycle while occupancy=2 -> everything returns to reset values, and following pushes start cleanly at pointer 0.
